// File: rtl/tron_pkg.sv
// ============================================================================
// Module : tron_pkg
// Brief  : Shared frame-buffer geometry, colour codes and trail_writer states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tron_pkg;

   localparam int H_RES          = 640;
   localparam int V_RES          = 480;
   localparam int WORDS_PER_LINE = 320;
   localparam int ADDR_W         = 19;
   localparam int FB_WORDS       = 153600;

   typedef enum logic [3:0] {
      BG         = 4'h8,
      BLUE_TRAIL = 4'h2,
      RED_TRAIL  = 4'h4
   } colour_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      SAMPLE  = 3'd2,
      WRITE_B = 3'd3,
      WRITE_R = 3'd4
   } state_t;

   // Both pixels of a word share one colour, so a trail write never needs a read.
   function automatic logic [15:0] trail_word(input colour_t c);
      return {4'h0, c, 4'h0, c};
   endfunction

endpackage

`default_nettype wire

// File: rtl/trail_writer_if.sv
// ============================================================================
// Module : trail_writer_if
// Brief  : Frame RAM write port (enable, word address, write word).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface trail_writer_if;

   logic                          WE;
   logic [tron_pkg::ADDR_W-1:0]   write_address;
   logic [15:0]                   Data_In;

   modport master (output WE, output write_address, output Data_In);
   modport slave  (input  WE, input  write_address, input  Data_In);

endinterface

`default_nettype wire

// File: rtl/pix_addr.sv
// ============================================================================
// Module : pix_addr
// Brief  : Maps a pixel position to its frame word address (x/2 + y*320).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pix_addr
   import tron_pkg::*;
(
   input  wire logic [9:0]        x,
   input  wire logic [9:0]        y,
   output logic      [ADDR_W-1:0] addr
);

   // y*320 as two shifts, done at full address width so nothing truncates.
   assign addr = ADDR_W'(x >> 1) + (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6);

endmodule

`default_nettype wire

// File: rtl/trail_writer.sv
// ============================================================================
// Module : trail_writer
// Brief  : Frame-buffer writer: full background clear and per-frame bike trails.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module trail_writer
   import tron_pkg::*;
#(
   parameter int CLEAR_WORDS = FB_WORDS
)
(
   input  wire logic         Clk,
   input  wire logic         Reset,
   input  wire logic         frame_clk,
   input  wire logic         clear_req,
   input  wire logic         blue_en,
   input  wire logic         red_en,
   input  wire logic [9:0]   Blue_X_real,
   input  wire logic [9:0]   Blue_Y_real,
   input  wire logic [9:0]   Red_X_real,
   input  wire logic [9:0]   Red_Y_real,
   trail_writer_if.master    fb,
   output logic              busy,
   output logic              clear_done
);

   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(CLEAR_WORDS - 1);

   state_t              r_state;
   state_t              w_next_state;
   logic [2:0]          r_sync;
   logic                w_tick;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [15:0]         r_data;
   logic                r_busy;
   logic                r_done;
   logic                w_we;
   logic [ADDR_W-1:0]   w_addr;
   logic [15:0]         w_data;
   logic                w_done;
   logic [ADDR_W-1:0]   w_clr_next;
   logic [9:0]          r_red_x;
   logic [9:0]          r_red_y;
   logic                r_red_en;
   logic [ADDR_W-1:0]   w_blue_addr;
   logic [ADDR_W-1:0]   w_red_addr;
   logic                w_blue_ok;
   logic                w_red_ok;

   pix_addr u_blue_addr (.x(Blue_X_real), .y(Blue_Y_real), .addr(w_blue_addr));
   pix_addr u_red_addr  (.x(r_red_x),     .y(r_red_y),     .addr(w_red_addr));

   // Rising edge of the twice-synchronised frame clock.
   assign w_tick     = r_sync[1] & ~r_sync[2];
   assign w_clr_next = r_addr + ADDR_W'(1);

   // Blue is consumed in the SAMPLE cycle straight into the output registers,
   // so only the red position needs holding for the following cycle.
   assign w_blue_ok = blue_en && (Blue_X_real < 10'(H_RES)) && (Blue_Y_real < 10'(V_RES));
   assign w_red_ok  = r_red_en && (r_red_x < 10'(H_RES)) && (r_red_y < 10'(V_RES));

   always_comb begin
      w_next_state = r_state;
      w_we         = 1'b0;
      w_addr       = r_addr;
      w_data       = r_data;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (clear_req) begin
               w_next_state = CLEAR;
               w_we         = 1'b1;
               w_addr       = '0;
               w_data       = trail_word(BG);
               w_done       = (c_last_addr == '0);
            end else if (w_tick) begin
               w_next_state = SAMPLE;
            end
         end
         CLEAR: begin
            if (r_addr == c_last_addr) begin
               w_next_state = IDLE;
            end else begin
               w_we   = 1'b1;
               w_addr = w_clr_next;
               w_done = (w_clr_next == c_last_addr);
            end
         end
         SAMPLE: begin
            w_next_state = WRITE_B;
            if (w_blue_ok) begin
               w_we   = 1'b1;
               w_addr = w_blue_addr;
               w_data = trail_word(BLUE_TRAIL);
            end
         end
         WRITE_B: begin
            w_next_state = WRITE_R;
            if (w_red_ok) begin
               w_we   = 1'b1;
               w_addr = w_red_addr;
               w_data = trail_word(RED_TRAIL);
            end
         end
         WRITE_R: w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state  <= IDLE;
         r_sync   <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_red_x  <= '0;
         r_red_y  <= '0;
         r_red_en <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_sync  <= {r_sync[1:0], frame_clk};
         r_we    <= w_we;
         r_addr  <= w_addr;
         r_data  <= w_data;
         r_busy  <= (w_next_state != IDLE);
         r_done  <= w_done;
         if (r_state == SAMPLE) begin
            r_red_x  <= Red_X_real;
            r_red_y  <= Red_Y_real;
            r_red_en <= red_en;
         end
      end
   end

   assign fb.WE            = r_we;
   assign fb.write_address = r_addr;
   assign fb.Data_In       = r_data;
   assign busy             = r_busy;
   assign clear_done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_trail_writer.sv
// ============================================================================
// Module : tb_trail_writer
// Brief  : Self-checking bench for trail_writer with a reference trail model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_trail_writer;
   import tron_pkg::*;

   localparam int CLR_N = 200;

   logic       Clk       = 1'b0;
   logic       Reset     = 1'b1;
   logic       frame_clk = 1'b0;
   logic       clear_req = 1'b0;
   logic       blue_en   = 1'b0;
   logic       red_en    = 1'b0;
   logic [9:0] bx = '0, by = '0, rx = '0, ry = '0;
   logic       busy;
   logic       clear_done;

   trail_writer_if fb ();

   trail_writer #(.CLEAR_WORDS(CLR_N)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_clk   (frame_clk),
      .clear_req   (clear_req),
      .blue_en     (blue_en),
      .red_en      (red_en),
      .Blue_X_real (bx),
      .Blue_Y_real (by),
      .Red_X_real  (rx),
      .Red_Y_real  (ry),
      .fb          (fb.master),
      .busy        (busy),
      .clear_done  (clear_done)
   );

   always #5 Clk = ~Clk;

   int tests = 0;
   int fails = 0;

   typedef struct {int n; int addr; int data;} wr_t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Raise frame_clk, watch 12 cycles and compare all writes against the model:
   // blue lands 4 edges after frame_clk rises, red 5 edges after.
   task automatic tick_frame(input string tag, input bit ben, input int x0, input int y0,
                             input bit ren, input int x1, input int y1, input int clr_at);
      wr_t exp_q[$];
      wr_t got_q[$];
      wr_t w;
      if (ben && x0 < H_RES && y0 < V_RES) begin
         w = '{4, x0 / 2 + y0 * WORDS_PER_LINE, 16'h0202};
         exp_q.push_back(w);
      end
      if (ren && x1 < H_RES && y1 < V_RES) begin
         w = '{5, x1 / 2 + y1 * WORDS_PER_LINE, 16'h0404};
         exp_q.push_back(w);
      end
      blue_en = ben; red_en = ren;
      bx = 10'(x0); by = 10'(y0); rx = 10'(x1); ry = 10'(y1);
      frame_clk = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         step();
         if (fb.WE === 1'b1) begin
            w = '{n, int'(fb.write_address), int'(fb.Data_In)};
            got_q.push_back(w);
         end
         clear_req = (n == clr_at);
         if (n == 8) frame_clk = 1'b0;
      end
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check({tag, "_cycle"}, got_q[i].n,    exp_q[i].n);
         check({tag, "_addr"},  got_q[i].addr, exp_q[i].addr);
         check({tag, "_data"},  got_q[i].data, exp_q[i].data);
      end
      check({tag, "_busy_end"}, busy, 1'b0);
   endtask

   initial begin
      int we_cnt;
      int done_cnt;

      // Reset state
      #2 Reset = 1'b0;
      #1;
      check("rst_we", fb.WE, 1'b0);
      check("rst_addr", fb.write_address, 0);
      check("rst_data", fb.Data_In, 0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", clear_done, 1'b0);
      step(); step();
      Reset = 1'b1;
      step(); step();
      check("idle_we", fb.WE, 1'b0);
      check("idle_busy", busy, 1'b0);

      // Directed trail cases
      tick_frame("basic",    1, 100, 50, 1, 101, 60, 0);
      tick_frame("corner",   1, 639, 479, 1, 0, 0, 0);
      tick_frame("blue_x",   1, 640, 10, 1, 20, 30, 0);
      tick_frame("blue_y",   1, 10, 480, 1, 21, 31, 0);
      tick_frame("same",     1, 200, 200, 1, 200, 200, 0);
      tick_frame("red_off",  1, 5, 6, 0, 7, 8, 0);
      tick_frame("clr_in_wb", 1, 300, 100, 1, 301, 101, 4);

      // Randomised trails, including out-of-range positions
      for (int k = 0; k < 20; k++) begin
         tick_frame("rand", 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                    1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), 0);
      end

      // Clear with a coincident tick, plus a tick mid-clear
      frame_clk = 1'b1;
      step(); step();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int i = 0; i < CLR_N; i++) begin
         check("clr_we", fb.WE, 1'b1);
         check("clr_addr", fb.write_address, i);
         check("clr_data", fb.Data_In, 16'h0808);
         check("clr_done", clear_done, (i == CLR_N - 1) ? 1'b1 : 1'b0);
         check("clr_busy", busy, 1'b1);
         if (i == 20) frame_clk = 1'b0;
         if (i == 40) frame_clk = 1'b1;
         step();
      end
      check("clr_end_busy", busy, 1'b0);
      check("clr_end_done", clear_done, 1'b0);
      we_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (fb.WE === 1'b1) we_cnt++;
         step();
      end
      check("clr_tick_dropped", we_cnt, 0);
      frame_clk = 1'b0;
      step(); step(); step();

      // Reset mid-clear: immediate reset values, clear not resumed
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int i = 0; i < 50; i++) step();
      #3 Reset = 1'b0;
      #1;
      check("mid_rst_we", fb.WE, 1'b0);
      check("mid_rst_addr", fb.write_address, 0);
      check("mid_rst_data", fb.Data_In, 0);
      check("mid_rst_busy", busy, 1'b0);
      step();
      Reset = 1'b1;
      we_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < CLR_N + 20; i++) begin
         step();
         if (fb.WE === 1'b1) we_cnt++;
         if (clear_done === 1'b1) done_cnt++;
      end
      check("mid_rst_no_we", we_cnt, 0);
      check("mid_rst_no_done", done_cnt, 0);

      tick_frame("post_rst", 1, 12, 34, 1, 56, 78, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/trail_writer.md
Name: trail_writer

Overview:
- Upstream producer for the frame-buffer write port: generates WE, write_address and the 16-bit write word consumed by the frame RAM that the pixel compositor reads.
- On a clear request, fills the whole 640x480 buffer with background.
- On each frame tick, stamps one trail word at the current blue and red bike positions.
- Runs entirely in the Clk domain. frame_clk is treated as a slow asynchronous input and synchronised internally.

Parameters:
- H_RES, 640, horizontal pixels
- V_RES, 480, vertical lines
- WORDS_PER_LINE, 320, frame words per line (2 pixels per word)
- ADDR_W, 19, write address width

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- frame_clk  in  1  ~60 Hz frame tick, asynchronous to Clk
- clear_req  in  1  one-Clk pulse: start full-buffer clear
- blue_en  in  1  stamp blue trail this frame
- red_en  in  1  stamp red trail this frame
- Blue_X_real, Blue_Y_real  in  10 each  blue bike pixel position
- Red_X_real, Red_Y_real  in  10 each  red bike pixel position
- WE  out  1  frame RAM write enable
- write_address  out  19  frame RAM word address
- Data_In  out  16  frame RAM write word
- busy  out  1  high in any state other than IDLE
- clear_done  out  1  one-Clk pulse when the last clear write has issued

Behaviour:
- Reset (async assert, sync release): state IDLE. WE=0, write_address=0, Data_In=0, busy=0, clear_done=0. Synchroniser flops=0.
- Word format: {4'h0, colour, 4'h0, colour}. Both pixels of the word take the same colour code, so trails are 2 px wide and no read-modify-write is needed.
- Colour codes: BG=4'h8, BLUE_TRAIL=4'h2, RED_TRAIL=4'h4.
- Address computation: addr = (X>>1) + (Y<<8) + (Y<<6), computed at 19 bits with no truncation. Maximum valid address is 153599.
- Frame tick: frame_clk passes through a 2-flop synchroniser; a rising edge of the synchronised signal produces a one-Clk tick.
- State machine:
  - IDLE -> CLEAR on clear_req (clear takes priority over a tick in the same cycle).
  - IDLE -> SAMPLE on tick.
  - CLEAR: WE=1, Data_In=16'h0808, address counter runs 0..153599, one write per Clk. On the final write, pulse clear_done in the same cycle, then go to IDLE. Duration is exactly 153600 cycles.
  - SAMPLE: latch all four positions and both enables; next state WRITE_B.
  - WRITE_B: if blue_en latched and X<640 and Y<480, then WE=1, Data_In=16'h0202, address from blue position; otherwise WE=0. Next state WRITE_R.
  - WRITE_R: same rule for red, Data_In=16'h0404. Next state IDLE.
- Latency: the blue write occurs 2 Clk after the tick cycle, and the red write 3 Clk after.
- Outputs are registered. write_address and Data_In hold their last values while WE=0.
- clear_req while busy: ignored (not queued).
- Tick during CLEAR, SAMPLE or WRITE_*: dropped.
- Reset asserted mid-CLEAR: immediate return to reset values. The partial clear is not resumed and clear_done does not pulse.
- Blue and red at the same word address: both writes issue in order, so red wins.

Decomposition:
- Package tron_pkg holds:
  - colour enum constants (BG, BLUE_TRAIL, RED_TRAIL)
  - H_RES, V_RES, WORDS_PER_LINE, FB_WORDS=153600
  - the state typedef (IDLE, CLEAR, SAMPLE, WRITE_B, WRITE_R)
- One sub-module, pix_addr: purely combinational, mapping X,Y to the 19-bit word address. Instanced twice, or once with a mux.

Test Plan:
- Reset low mid-operation, then release -> WE=0, write_address=0, Data_In=0, busy=0 immediately on assertion.
- clear_req pulse -> exactly 153600 consecutive WE=1 cycles, Data_In=16'h0808 throughout, addresses 0..153599 in order, clear_done coincident with address 153599, busy drops the next cycle.
- Blue (100,50), red (101,60), both enabled, frame_clk rising -> blue write addr 16050 data 16'h0202, then red write addr 19250 data 16'h0404.
- Blue (639,479) -> addr 153599. Blue X=640 or Y=480 -> no WE in WRITE_B, red write still occurs.
- Blue and red both at (200,200), tick -> two writes to addr 64100, the second with 16'h0404.
- clear_req and tick in the same cycle -> CLEAR entered, tick dropped. A tick during CLEAR produces no trail writes. clear_req during WRITE_B -> ignored.
